uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
//   uart_state_t  : frame FSM states, common to both directions
//   UART_NB_TICKS : default oversampling ticks per bit period
package uart_pkg;

    localparam int UART_NB_TICKS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   i_clk   : destination clock
//   i_reset : synchronous active-high reset, both flops load RESET_VAL
//   i_d     : asynchronous input
//   o_q     : synchronized output, two i_clk cycles of latency
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta <= RESET_VAL;
            o_q  <= RESET_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 1 start bit, NB_DATA data bits LSB first, 1 stop bit.
// Ports:
//   i_clk         : system clock
//   i_reset       : synchronous active-high reset
//   i_tick        : oversampling strobe, NB_TICKS per bit period
//   i_rx_data     : asynchronous serial line, idle high
//   o_data        : last correctly framed word
//   o_valid       : one-cycle pulse when o_data is updated
//   o_frame_error : one-cycle pulse when the stop bit samples low
//
// state | meaning
// IDLE  | waiting for the line to go low (and, after a break, to return high first)
// START | counting to mid start bit to confirm it is not a glitch
// DATA  | sampling each data bit at its middle
// STOP  | sampling the stop bit at its middle, then report
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA  = 8,
    parameter int NB_TICKS = UART_NB_TICKS
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_frame_error
);

    localparam int TW = $clog2(NB_TICKS);
    localparam int BW = $clog2(NB_DATA + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(NB_TICKS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(NB_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

    logic               rx;
    uart_state_t        state;
    uart_state_t        state_nxt;
    logic [TW-1:0]      tick_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [NB_DATA-1:0] shreg;
    // Set by a frame error; blocks start detection until the line has gone
    // high again, so a held-low line reports a single error.
    logic               brk;

    logic start_seen;
    logic start_check;
    logic bit_sample;
    logic stop_sample;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx_data),
        .o_q     (rx)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_seen) state_nxt = START;
            START:   if (start_check) state_nxt = rx ? IDLE : DATA;
            DATA:    if (bit_sample && (bit_cnt == BIT_LAST)) state_nxt = STOP;
            STOP:    if (stop_sample) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_seen  = 1'b0;
        start_check = 1'b0;
        bit_sample  = 1'b0;
        stop_sample = 1'b0;
        case (state)
            IDLE:    start_seen  = !rx && !brk;
            START:   start_check = i_tick && (tick_cnt == TICK_MID);
            DATA:    bit_sample  = i_tick && (tick_cnt == TICK_LAST);
            STOP:    stop_sample = i_tick && (tick_cnt == TICK_LAST);
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            brk           <= 1'b0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (brk && rx) brk <= 1'b0;
                    if (start_seen) tick_cnt <= '0;
                end
                START: begin
                    if (start_check) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end else if (i_tick) begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_sample) begin
                        shreg    <= {rx, shreg[NB_DATA-1:1]};
                        tick_cnt <= '0;
                        bit_cnt  <= bit_cnt + BW'(1);
                    end else if (i_tick) begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                STOP: begin
                    if (stop_sample) begin
                        tick_cnt <= '0;
                        if (rx) begin
                            o_data  <= shreg;
                            o_valid <= 1'b1;
                        end else begin
                            o_frame_error <= 1'b1;
                            brk           <= 1'b1;
                        end
                    end else if (i_tick) begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// compared against a frame-level model (expected word and pulse counts).
module tb_uart_rx;

    localparam int NB_DATA  = 8;
    localparam int NB_TICKS = 16;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_tick;
    logic               i_rx_data;
    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               o_frame_error;

    uart_rx #(
        .NB_DATA  (NB_DATA),
        .NB_TICKS (NB_TICKS)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_tick        (i_tick),
        .i_rx_data     (i_rx_data),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_frame_error (o_frame_error)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    int tick_div   = 4;
    int tick_phase = 0;

    always @(negedge i_clk) begin
        tick_phase = (tick_phase + 1) % tick_div;
        i_tick     = (tick_phase == 0);
    end

    int n_valid   = 0;
    int n_ferr    = 0;
    int n_overlap = 0;

    always @(negedge i_clk) begin
        if (o_valid) n_valid++;
        if (o_frame_error) n_ferr++;
        if (o_valid && o_frame_error) n_overlap++;
    end

    logic [NB_DATA-1:0] exp_data = '0;
    int                 exp_valid_total = 0;
    int                 exp_ferr_total  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold_line(input logic val, input int clks);
        i_rx_data = val;
        repeat (clks) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [NB_DATA-1:0] d, input logic stop_b);
        int bit_clks;
        bit_clks = NB_TICKS * tick_div;
        hold_line(1'b0, bit_clks);
        for (int i = 0; i < NB_DATA; i++) hold_line(d[i], bit_clks);
        hold_line(stop_b, bit_clks);
    endtask

    // Sends one frame and checks the outcome the frame rules predict:
    // good stop -> one valid pulse with the word; bad stop -> one error pulse,
    // word unchanged.
    task automatic run_frame(input string tag, input logic [NB_DATA-1:0] d, input logic stop_b);
        int v0;
        int f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(d, stop_b);
        if (stop_b) begin
            exp_data = d;
            exp_valid_total++;
        end else begin
            exp_ferr_total++;
        end
        check_eq($sformatf("%s_valid", tag), n_valid - v0, stop_b ? 1 : 0);
        check_eq($sformatf("%s_ferr", tag), n_ferr - f0, stop_b ? 0 : 1);
        check_eq($sformatf("%s_data", tag), o_data, exp_data);
    endtask

    initial begin
        int v0;
        int f0;
        logic [NB_DATA-1:0] rd;
        logic               rs;
        int                 gap;

        i_reset   = 1'b1;
        i_rx_data = 1'b1;
        repeat (5) @(negedge i_clk);
        check_eq("rst_data", o_data, 0);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_ferr", o_frame_error, 0);
        i_reset = 1'b0;
        hold_line(1'b1, 20);

        // Tick every 4 clocks, good frame
        tick_div = 4;
        run_frame("a5", 8'hA5, 1'b1);
        hold_line(1'b1, 64);

        // Short low glitch is rejected, then a normal frame
        v0 = n_valid;
        f0 = n_ferr;
        hold_line(1'b0, 4 * tick_div);
        hold_line(1'b1, 3 * NB_TICKS * tick_div);
        check_eq("glitch_valid", n_valid - v0, 0);
        check_eq("glitch_ferr", n_ferr - f0, 0);
        run_frame("3c", 8'h3C, 1'b1);
        hold_line(1'b1, 64);

        // Bad stop bit after a good word leaves the word in place
        run_frame("11", 8'h11, 1'b1);
        hold_line(1'b1, 64);
        run_frame("3c_bad", 8'h3C, 1'b0);
        hold_line(1'b1, 2 * NB_TICKS * tick_div);

        // Reset mid-frame discards the partial word
        v0 = n_valid;
        f0 = n_ferr;
        hold_line(1'b0, NB_TICKS * tick_div);
        hold_line(1'b1, 3 * NB_TICKS * tick_div);
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        check_eq("midrst_data", o_data, 0);
        check_eq("midrst_valid", o_valid, 0);
        check_eq("midrst_ferr", o_frame_error, 0);
        i_reset  = 1'b0;
        exp_data = '0;
        hold_line(1'b1, 2 * NB_TICKS * tick_div);
        check_eq("midrst_no_pulse_v", n_valid - v0, 0);
        check_eq("midrst_no_pulse_f", n_ferr - f0, 0);
        check_eq("midrst_hold_data", o_data, 0);
        run_frame("5a", 8'h5A, 1'b1);
        hold_line(1'b1, 64);

        // Back-to-back frames with no idle gap
        run_frame("b2b_00", 8'h00, 1'b1);
        run_frame("b2b_ff", 8'hFF, 1'b1);
        hold_line(1'b1, 64);

        // Tick on every cycle
        tick_div = 1;
        run_frame("81", 8'h81, 1'b1);
        hold_line(1'b1, 32);

        // Line held low: exactly one frame error, then silence until it rises
        tick_div = 2;
        v0 = n_valid;
        f0 = n_ferr;
        hold_line(1'b0, 30 * NB_TICKS * tick_div);
        check_eq("break_valid", n_valid - v0, 0);
        check_eq("break_ferr", n_ferr - f0, 1);
        exp_ferr_total++;
        hold_line(1'b1, 2 * NB_TICKS * tick_div);
        run_frame("after_break", 8'h22, 1'b1);
        hold_line(1'b1, 32);

        // Randomized frames, tick rates and gaps
        for (int n = 0; n < 24; n++) begin
            tick_div = $urandom_range(1, 4);
            rd       = NB_DATA'($urandom);
            rs       = ($urandom_range(0, 3) != 0);
            run_frame($sformatf("rnd%0d", n), rd, rs);
            gap = rs ? $urandom_range(0, 2) : $urandom_range(1, 2);
            hold_line(1'b1, gap * NB_TICKS * tick_div);
        end

        hold_line(1'b1, 32);
        check_eq("no_overlap", n_overlap, 0);
        check_eq("total_valid", n_valid, exp_valid_total);
        check_eq("total_ferr", n_ferr, exp_ferr_total);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
